// File: rtl/regbank_wr_seq.sv
// regbank_wr_seq: FIFO-buffered write sequencer issuing one-hot register loads.
// Optional `REGBANK_WR_ERRCNT_EN adds a saturating err_cnt output.
module regbank_wr_seq #(
    parameter int A     = 8,
    parameter int D     = 8,
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [A-1:0] req_addr,
    input  logic [D-1:0] req_data,
    input  logic         hold,
    output logic [N-1:0] wr_select,
    output logic [D-1:0] wr_data,
    output logic         err,
`ifdef REGBANK_WR_ERRCNT_EN
    output logic [7:0]   err_cnt,
`endif
    output logic         busy
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;
    localparam logic [A:0] NLIM = (A+1)'(N);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state, state_nxt;

    logic [A-1:0] mem_addr [DEPTH];
    logic [D-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic full, empty, push, pop;
    logic [A-1:0] rd_addr;
    logic [D-1:0] rd_data;
    logic         in_range;

    logic [N-1:0] sel_nxt;
    logic [D-1:0] data_nxt;
    logic         err_nxt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    // No pass-through: a full FIFO refuses even when popping this cycle.
    assign req_ready = !full && !reset;
    assign push      = req_valid && req_ready;
    assign pop       = !empty && !hold && !reset;

    assign rd_addr  = mem_addr[rd_ptr[IW-1:0]];
    assign rd_data  = mem_data[rd_ptr[IW-1:0]];
    assign in_range = ({1'b0, rd_addr} < NLIM);

    assign busy = !reset && (!empty || (wr_select != '0));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[IW-1:0]] <= req_addr;
            mem_data[wr_ptr[IW-1:0]] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = '0;
        data_nxt  = wr_data;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE:  if (pop)  state_nxt = ISSUE;
            ISSUE: if (!pop) state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
        if (pop) begin
            if (in_range) begin
                for (int i = 0; i < N; i++)
                    sel_nxt[i] = (rd_addr == A'(i));
                data_nxt = rd_data;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_select <= '0;
            wr_data   <= '0;
            err       <= 1'b0;
        end else begin
            wr_select <= sel_nxt;
            wr_data   <= data_nxt;
            err       <= err_nxt;
        end
    end

`ifdef REGBANK_WR_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset)                        err_cnt <= '0;
        else if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_regbank_wr_seq.sv
// Directed self-checking bench for regbank_wr_seq.
// Defining REGBANK_WR_ERRCNT_EN also exercises err_cnt.
module tb_regbank_wr_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       hold;
    logic [3:0] wr_select;
    logic [7:0] wr_data;
    logic       err;
    logic       busy;
`ifdef REGBANK_WR_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regbank_wr_seq #(.A(8), .D(8), .N(4), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .hold      (hold),
        .wr_select (wr_select),
        .wr_data   (wr_data),
        .err       (err),
`ifdef REGBANK_WR_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sel,
                           input logic [7:0] dat, input logic e);
        chk({tag, "_sel"}, 32'(wr_select), 32'(sel));
        chk({tag, "_data"}, 32'(wr_data), 32'(dat));
        chk({tag, "_err"}, 32'(err), 32'(e));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        hold      = 1'b0;
        step();
        step();
        chk_out("rst", 4'h0, 8'h00, 1'b0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(req_ready), 32'd1);

        // single write
        req_valid = 1'b1; req_addr = 8'd2; req_data = 8'h5A;
        step();
        req_valid = 1'b0;
        chk_out("single_k", 4'h0, 8'h00, 1'b0);
        step();
        chk_out("single_k1", 4'b0100, 8'h5A, 1'b0);
        chk("single_busy", 32'(busy), 32'd1);
        step();
        chk_out("single_k2", 4'h0, 8'h5A, 1'b0);
        chk("single_idle", 32'(busy), 32'd0);

        // back-to-back
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 8'(i);
            req_data  = 8'((i + 1) * 8'h11);
            chk("b2b_ready", 32'(req_ready), 32'd1);
            step();
            if (i > 0)
                chk_out("b2b", 4'(1 << (i - 1)), 8'(i * 8'h11), 1'b0);
        end
        req_valid = 1'b0;
        step();
        chk_out("b2b_last", 4'b1000, 8'h44, 1'b0);
        step();
        chk_out("b2b_end", 4'h0, 8'h44, 1'b0);

        // hold while filling
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = 8'(i % 4);
            req_data  = 8'(8'hA0 + i);
            chk("hold_ready", 32'(req_ready), 32'(i < 4));
            step();
            chk("hold_sel", 32'(wr_select), 32'd0);
        end
        hold = 1'b0;
        #1;
        chk("full_ready", 32'(req_ready), 32'd0);
        step();
        chk_out("drain0", 4'b0001, 8'hA0, 1'b0);
        chk("drain_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk_out("drain1", 4'b0010, 8'hA1, 1'b0);
        step();
        chk_out("drain2", 4'b0100, 8'hA2, 1'b0);
        step();
        chk_out("drain3", 4'b1000, 8'hA3, 1'b0);
        step();
        chk_out("drain4", 4'b0001, 8'hA4, 1'b0);
        step();
        chk_out("drain_end", 4'h0, 8'hA4, 1'b0);
        chk("drain_busy", 32'(busy), 32'd0);

        // out-of-range between valid writes
        req_valid = 1'b1; req_addr = 8'd1; req_data = 8'h31;
        step();
        req_addr = 8'd9; req_data = 8'h99;
        step();
        chk_out("oor_pre", 4'b0010, 8'h31, 1'b0);
        req_addr = 8'd3; req_data = 8'h33;
        step();
        req_valid = 1'b0;
        chk_out("oor_slot", 4'h0, 8'h31, 1'b1);
        step();
        chk_out("oor_post", 4'b1000, 8'h33, 1'b0);
`ifdef REGBANK_WR_ERRCNT_EN
        chk("oor_cnt", 32'(err_cnt), 32'd1);
`endif
        step();

        // reset with queued entries
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 8'(i);
            req_data  = 8'(8'hC0 + i);
            step();
        end
        req_valid = 1'b0;
        hold  = 1'b0;
        reset = 1'b1;
        step();
        chk_out("mrst", 4'h0, 8'h00, 1'b0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("mrst_rel", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_nostrobe", 32'(wr_select), 32'd0);
        end
        chk("mrst_idle", 32'(busy), 32'd0);

`ifdef REGBANK_WR_ERRCNT_EN
        chk("cnt_rst", 32'(err_cnt), 32'd0);
        req_valid = 1'b1; req_addr = 8'hFF; req_data = 8'h00;
        for (int i = 0; i < 300; i++) begin
            step();
            chk("sat_sel", 32'(wr_select), 32'd0);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("cnt_sat", 32'(err_cnt), 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_wr_seq.md
# regbank_wr_seq

Write sequencer for a bank of N D-bit `select`-loaded registers. It accepts write requests (address plus data) through a valid/ready handshake and buffers them in a small FIFO. It issues each request as a one-cycle one-hot `wr_select` pulse with matching `wr_data`, at most one register per cycle. It sits directly upstream of the register bank: `wr_data` fans out to every register's `data` input, and `wr_select[i]` drives register i's `select`.

## Interface
- `A`, 8, request address width
- `D`, 8, data width; must match the register bank
- `N`, 4, number of registers driven; 1 ≤ N ≤ 2^A
- `DEPTH`, 4, request FIFO depth; power of two, ≥ 2
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: FIFO can accept a request.
- `req_addr` input A: target register index.
- `req_data` input D: value to write.
- `hold` input 1: downstream pause; suppresses issue.
- `wr_select` output N: one-hot load strobe, registered.
- `wr_data` output D: write data, registered.
- `err` output 1: one-cycle pulse on an out-of-range address, registered.
- `busy` output 1: FIFO non-empty or a strobe is active this cycle.

## Operation
- Reset: FIFO emptied. `wr_select`=0, `wr_data`=0, `err`=0, `req_ready`=0 while `reset` is high, `busy`=0.
- Accept: a handshake occurs on a clock edge with `req_valid && req_ready`; {addr, data} is pushed.
- `req_ready` = !full && !reset. There is no pass-through: when full, `req_ready` is 0 even if a pop occurs in the same cycle.
- FSM has two states.
  - IDLE: `wr_select`=0. Go to ISSUE on an edge where the FIFO is non-empty and `hold`=0.
  - ISSUE: the popped entry is presented. Stay in ISSUE while the FIFO is non-empty and `hold`=0. Otherwise return to IDLE.
- Pop/issue at an edge where the FIFO is non-empty and `hold`=0:
  - If addr < N: `wr_select` ← (1 << addr), `wr_data` ← data.
  - If addr ≥ N: `wr_select` ← 0, `wr_data` unchanged, `err` ← 1. The entry is discarded but still consumes that issue cycle.
- At any edge with no pop: `wr_select` ← 0 and `err` ← 0. `wr_data` keeps its last value.
- Simultaneous push and pop when not full: both occur and the occupancy is unchanged.
- Wrap-around: read and write pointers are log2(DEPTH)+1 bits. Full = MSBs differ and LSBs are equal. Empty = pointers are equal.
- `reset` mid-burst: the FIFO is flushed with no further strobes. A strobe already registered in that cycle is cleared at the reset edge.

## Timing
- Latency: a request accepted at edge k into an empty FIFO produces `wr_select`/`wr_data` valid from edge k+1 to edge k+2. The target register loads at edge k+2.
- Throughput: one write per cycle. `wr_select` may be asserted on consecutive cycles to different or identical indices.
- `hold` is sampled at the edge. With `hold`=1 at edge k, no strobe is issued during cycle k..k+1. Data in the FIFO is retained.
- `wr_select` is never multi-hot, and `err` and `wr_select` are never non-zero in the same cycle.

## Configuration
- `REGBANK_WR_ERRCNT_EN`
  - Defined: adds output `err_cnt` [7:0]. It resets to 0, increments on every `err` pulse, and saturates at 255.
  - Undefined: the port and the counter are absent, and `err` behaviour is identical.

## Test plan
- Reset, then a single write (addr=2, data=0x5A) into an empty FIFO: `wr_select`=4'b0100 and `wr_data`=0x5A for exactly one cycle, one cycle after acceptance.
- Back-to-back writes to addr 0,1,2,3 with data 0x11..0x44 and `req_valid` held high: four consecutive one-hot strobes 0001, 0010, 0100, 1000 with matching data, and `req_ready` never drops.
- `hold`=1 while pushing 5 requests (DEPTH=4): `req_ready` drops after the 4th; the 5th stays pending. Release `hold`: 4 strobes in order, then the 5th is accepted and issued.
- addr=9 (N=4) between two valid writes: a one-cycle `err` pulse with `wr_select`=0 in that slot, neighbouring writes unaffected, and `err_cnt`=1 when the macro is defined.
- Assert `reset` for one cycle while 3 entries are queued: all outputs are 0 the next cycle, no further strobes, and `req_ready`=1 after release.
- With the macro defined, 300 out-of-range requests: `err_cnt` saturates at 255.
